box_cmd_decoder: RTL and testbench



---
 rtl/box_cmd_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_box_cmd_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/box_cmd_decoder.sv
// Box-overlay command decoder. Parses MAGIC/opcode packets from the UDP RX
// byte stream, validates them, holds the result in a pending register and
// applies it to the box outputs only on a vsync rising edge.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for first byte of a packet; checks it against MAGIC
// RECV  | MAGIC seen; capturing opcode and payload, counting bytes
// DRAIN | bad MAGIC; swallowing the rest of the packet, then error
module box_cmd_decoder #(
    parameter int unsigned H_ACT     = 1280,
    parameter int unsigned V_ACT     = 720,
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter logic [23:0] DEF_COLOR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid,
    input  logic [7:0]  i_data,
    input  logic [15:0] data_len,
    input  logic        vsync,
    output logic [10:0] start_x,
    output logic [9:0]  start_y,
    output logic [10:0] end_x,
    output logic [9:0]  end_y,
    output logic [23:0] color,
    output logic        box_en,
    output logic        cmd_err,
    output logic [7:0]  cmd_cnt
);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

    localparam logic [15:0] H_LIM   = 16'(H_ACT);
    localparam logic [15:0] V_LIM   = 16'(V_ACT);
    localparam logic [15:0] LEN_SET = 16'd13;
    localparam logic [15:0] LEN_CLR = 16'd2;

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  len_q, len_d;
    logic [7:0]   op_q, op_d;
    // Payload bytes 2..12 shifted in MSB-first: x0,y0,x1,y1 (16b each), R,G,B.
    logic [87:0]  pay_q, pay_d;

    logic [10:0]  p_sx_q, p_sx_d, p_ex_q, p_ex_d;
    logic [9:0]   p_sy_q, p_sy_d, p_ey_q, p_ey_d;
    logic [23:0]  p_col_q, p_col_d;
    logic         p_en_q, p_en_d;
    logic         flag_q, flag_d;

    logic [10:0]  sx_q, sx_d, ex_q, ex_d;
    logic [9:0]   sy_q, sy_d, ey_q, ey_d;
    logic [23:0]  col_q, col_d;
    logic         en_q, en_d;
    logic         err_q, err_d;
    logic [7:0]   ccnt_q, ccnt_d;

    logic         vs_s1_q, vs_s2_q, vs_s3_q;
    logic         vs_rise;

    logic [15:0]  x0, y0, x1, y1;
    logic         set_op, clr_op, range_ok, pkt_ok;

    assign x0 = pay_q[87:72];
    assign y0 = pay_q[71:56];
    assign x1 = pay_q[55:40];
    assign y1 = pay_q[39:24];

    assign set_op   = (op_q == 8'h01);
    assign clr_op   = (op_q == 8'h00);
    assign range_ok = (x0 <= x1) && (x1 < H_LIM) && (y0 <= y1) && (y1 < V_LIM);
    assign pkt_ok   = (cnt_q == len_q) &&
                      ((set_op && cnt_q == LEN_SET && range_ok) ||
                       (clr_op && cnt_q == LEN_CLR));

    assign vs_rise = vs_s2_q & ~vs_s3_q;

    // vsync synchroniser; s2 is the first flop considered stable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_s1_q <= 1'b0;
            vs_s2_q <= 1'b0;
            vs_s3_q <= 1'b0;
        end else begin
            vs_s1_q <= vsync;
            vs_s2_q <= vs_s1_q;
            vs_s3_q <= vs_s2_q;
        end
    end

    // Packet FSM, evaluation, pending register and frame-boundary apply.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        op_d    = op_q;
        pay_d   = pay_q;
        p_sx_d  = p_sx_q;
        p_sy_d  = p_sy_q;
        p_ex_d  = p_ex_q;
        p_ey_d  = p_ey_q;
        p_col_d = p_col_q;
        p_en_d  = p_en_q;
        flag_d  = flag_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        col_d   = col_q;
        en_d    = en_q;
        err_d   = 1'b0;
        ccnt_d  = ccnt_q;

        // Apply first so a same-cycle accept leaves the flag set for next frame.
        if (vs_rise && flag_q) begin
            sx_d   = p_sx_q;
            sy_d   = p_sy_q;
            ex_d   = p_ex_q;
            ey_d   = p_ey_q;
            col_d  = p_col_q;
            en_d   = p_en_q;
            flag_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (valid) begin
                    len_d = data_len;
                    if (i_data == MAGIC) begin
                        state_d = RECV;
                        cnt_d   = 16'd1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            RECV: begin
                if (valid) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    if (cnt_q == 16'd1)       op_d  = i_data;
                    else if (cnt_q < LEN_SET) pay_d = {pay_q[79:0], i_data};
                end else begin
                    state_d = IDLE;
                    if (pkt_ok) begin
                        if (set_op) begin
                            p_sx_d  = x0[10:0];
                            p_sy_d  = y0[9:0];
                            p_ex_d  = x1[10:0];
                            p_ey_d  = y1[9:0];
                            p_col_d = pay_q[23:0];
                        end
                        p_en_d = set_op;
                        flag_d = 1'b1;
                        ccnt_d = ccnt_q + 8'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!valid) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            op_q    <= '0;
            pay_q   <= '0;
            p_sx_q  <= '0;
            p_sy_q  <= '0;
            p_ex_q  <= '0;
            p_ey_q  <= '0;
            p_col_q <= DEF_COLOR;
            p_en_q  <= 1'b0;
            flag_q  <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            col_q   <= DEF_COLOR;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            ccnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            op_q    <= op_d;
            pay_q   <= pay_d;
            p_sx_q  <= p_sx_d;
            p_sy_q  <= p_sy_d;
            p_ex_q  <= p_ex_d;
            p_ey_q  <= p_ey_d;
            p_col_q <= p_col_d;
            p_en_q  <= p_en_d;
            flag_q  <= flag_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            col_q   <= col_d;
            en_q    <= en_d;
            err_q   <= err_d;
            ccnt_q  <= ccnt_d;
        end
    end

    assign start_x = sx_q;
    assign start_y = sy_q;
    assign end_x   = ex_q;
    assign end_y   = ey_q;
    assign color   = col_q;
    assign box_en  = en_q;
    assign cmd_err = err_q;
    assign cmd_cnt = ccnt_q;

endmodule

// File: tb/tb_box_cmd_decoder.sv
// Directed bench for box_cmd_decoder with hand-computed expectations.
module tb_box_cmd_decoder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic [15:0] data_len = 16'd0;
    logic        vsync = 1'b0;
    logic [10:0] start_x;
    logic [9:0]  start_y;
    logic [10:0] end_x;
    logic [9:0]  end_y;
    logic [23:0] color;
    logic        box_en;
    logic        cmd_err;
    logic [7:0]  cmd_cnt;

    int checks = 0;
    int failures = 0;
    logic [7:0] pkt_b [16];

    box_cmd_decoder dut (
        .clk(clk), .rstn(rstn), .valid(valid), .i_data(i_data),
        .data_len(data_len), .vsync(vsync),
        .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
        .color(color), .box_en(box_en), .cmd_err(cmd_err), .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_box(input string tag, input logic [10:0] sx, input logic [9:0] sy,
                           input logic [10:0] ex, input logic [9:0] ey,
                           input logic [23:0] c, input logic en);
        chk({tag, "_sx"}, 32'(start_x), 32'(sx));
        chk({tag, "_sy"}, 32'(start_y), 32'(sy));
        chk({tag, "_ex"}, 32'(end_x), 32'(ex));
        chk({tag, "_ey"}, 32'(end_y), 32'(ey));
        chk({tag, "_col"}, 32'(color), 32'(c));
        chk({tag, "_en"}, 32'(box_en), 32'(en));
    endtask

    task automatic mk_set(input logic [15:0] x0, input logic [15:0] y0,
                          input logic [15:0] x1, input logic [15:0] y1, input logic [23:0] c);
        pkt_b[0]  = 8'hA5;      pkt_b[1]  = 8'h01;
        pkt_b[2]  = x0[15:8];   pkt_b[3]  = x0[7:0];
        pkt_b[4]  = y0[15:8];   pkt_b[5]  = y0[7:0];
        pkt_b[6]  = x1[15:8];   pkt_b[7]  = x1[7:0];
        pkt_b[8]  = y1[15:8];   pkt_b[9]  = y1[7:0];
        pkt_b[10] = c[23:16];   pkt_b[11] = c[15:8];   pkt_b[12] = c[7:0];
    endtask

    task automatic mk_clr();
        pkt_b[0] = 8'hA5;
        pkt_b[1] = 8'h00;
    endtask

    // Sends n bytes; raises vsync while driving byte vs_at (-1: never).
    // Returns just after the edge that ends the first valid-low cycle.
    task automatic send(input int n, input logic [15:0] dlen, input int vs_at);
        data_len = dlen;
        for (int i = 0; i < n; i++) begin
            valid  = 1'b1;
            i_data = pkt_b[i];
            if (i == vs_at) vsync = 1'b1;
            tick();
        end
        valid = 1'b0;
        tick();
    endtask

    task automatic do_vsync();
        vsync = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        repeat (2) tick();
        chk_box("reset", 11'd0, 10'd0, 11'd0, 10'd0, 24'hFF0000, 1'b0);
        chk("reset_err", 32'(cmd_err), 32'd0);
        chk("reset_cnt", 32'(cmd_cnt), 32'd0);
        rstn = 1'b1;
        tick();

        // Basic SET with step-wise apply latency check.
        mk_set(16'd100, 16'd100, 16'd300, 16'd300, 24'hFF0000);
        send(13, 16'd13, -1);
        chk("set_err", 32'(cmd_err), 32'd0);
        chk("set_cnt", 32'(cmd_cnt), 32'd1);
        chk("set_pre_apply_en", 32'(box_en), 32'd0);
        vsync = 1'b1;
        tick();
        chk("vs_e1_en", 32'(box_en), 32'd0);
        tick();
        chk("vs_e2_sx", 32'(start_x), 32'd0);
        tick();
        chk_box("vs_e3", 11'd100, 10'd100, 11'd300, 10'd300, 24'hFF0000, 1'b1);
        vsync = 1'b0;
        repeat (3) tick();

        // Range error: x1 = 1280.
        mk_set(16'd100, 16'd100, 16'h0500, 16'd300, 24'h00FF00);
        send(13, 16'd13, -1);
        chk("range_err", 32'(cmd_err), 32'd1);
        chk("range_cnt", 32'(cmd_cnt), 32'd1);
        tick();
        chk("range_err_pulse", 32'(cmd_err), 32'd0);
        do_vsync();
        chk_box("range_out", 11'd100, 10'd100, 11'd300, 10'd300, 24'hFF0000, 1'b1);

        // Length errors.
        mk_set(16'd1, 16'd1, 16'd2, 16'd2, 24'h123456);
        send(12, 16'd13, -1);
        chk("short_err", 32'(cmd_err), 32'd1);
        pkt_b[13] = 8'h00;
        send(14, 16'd14, -1);
        chk("long_err", 32'(cmd_err), 32'd1);
        pkt_b[0] = 8'h5A;
        pkt_b[1] = 8'h00;
        send(2, 16'd2, -1);
        chk("magic_err", 32'(cmd_err), 32'd1);
        chk("lenerr_cnt", 32'(cmd_cnt), 32'd1);

        // Last wins, then CLEAR.
        mk_set(16'd10, 16'd20, 16'd30, 16'd40, 24'h00FF00);
        send(13, 16'd13, -1);
        chk("boxa_err", 32'(cmd_err), 32'd0);
        mk_set(16'd50, 16'd60, 16'd70, 16'd80, 24'h0000FF);
        send(13, 16'd13, -1);
        chk("lastwin_cnt", 32'(cmd_cnt), 32'd3);
        do_vsync();
        chk_box("lastwin", 11'd50, 10'd60, 11'd70, 10'd80, 24'h0000FF, 1'b1);
        mk_clr();
        send(2, 16'd2, -1);
        chk("clr_cnt", 32'(cmd_cnt), 32'd4);
        chk("clr_err", 32'(cmd_err), 32'd0);
        do_vsync();
        chk_box("clr", 11'd50, 10'd60, 11'd70, 10'd80, 24'h0000FF, 1'b0);

        // Accept and apply in the same cycle.
        mk_set(16'd1, 16'd2, 16'd3, 16'd4, 24'h112233);
        send(13, 16'd13, -1);
        mk_set(16'd5, 16'd6, 16'd7, 16'd8, 24'h445566);
        send(13, 16'd13, 11);
        chk_box("coinc_old", 11'd1, 10'd2, 11'd3, 10'd4, 24'h112233, 1'b1);
        chk("coinc_cnt", 32'(cmd_cnt), 32'd6);
        do_vsync();
        chk_box("coinc_new", 11'd5, 10'd6, 11'd7, 10'd8, 24'h445566, 1'b1);

        // Reset mid-packet.
        mk_set(16'd100, 16'd100, 16'd300, 16'd300, 24'hFF0000);
        data_len = 16'd13;
        for (int i = 0; i < 6; i++) begin
            valid  = 1'b1;
            i_data = pkt_b[i];
            tick();
        end
        i_data = pkt_b[6];
        rstn = 1'b0;
        #1;
        chk_box("midrst", 11'd0, 10'd0, 11'd0, 10'd0, 24'hFF0000, 1'b0);
        chk("midrst_cnt", 32'(cmd_cnt), 32'd0);
        tick();
        rstn = 1'b1;
        for (int i = 7; i < 13; i++) begin
            valid  = 1'b1;
            i_data = pkt_b[i];
            tick();
        end
        valid = 1'b0;
        tick();
        chk("tail_drain_err", 32'(cmd_err), 32'd1);
        chk("tail_cnt", 32'(cmd_cnt), 32'd0);
        send(13, 16'd13, -1);
        chk("postrst_cnt", 32'(cmd_cnt), 32'd1);
        chk("postrst_err", 32'(cmd_err), 32'd0);
        do_vsync();
        chk_box("postrst", 11'd100, 10'd100, 11'd300, 10'd300, 24'hFF0000, 1'b1);

        // Counter wrap: from 1, 254 CLEARs reach 255, one more wraps to 0.
        mk_clr();
        for (int i = 0; i < 254; i++) send(2, 16'd2, -1);
        chk("wrap_255", 32'(cmd_cnt), 32'd255);
        send(2, 16'd2, -1);
        chk("wrap_0", 32'(cmd_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
